// File: rtl/mmio_memory_responder.sv
// ---------------------------------------------------------------------------
// mmio_memory_responder
//
// Responder end of the rv32i core memory interface. Holds a word-addressed
// RAM and a small MMIO page (LED register, free-running cycle counter, byte
// TX FIFO with a valid/ready output stream, and a sticky status/fault
// register). Reads are combinational so the core can latch data in the same
// state that drives the address; every write lands on the rising clock edge.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous reset, active low (0 = reset)
//   mem_addr     in   32-bit byte address from the core
//   mem_wr_data  in   32-bit write data
//   mem_wr_ena   in   write strobe, sampled on the rising edge
//   mem_rd_data  out  32-bit combinational read data (0 while in reset)
//   leds         out  LED register contents
//   tx_data      out  head byte of the TX FIFO (0 when empty)
//   tx_valid     out  TX FIFO not empty
//   tx_ready     in   downstream sink accepts tx_data on this edge
//   fault        out  OR of all sticky fault bits
//
// MMIO page (mem_addr[31:28] == 4'hF, bits [27:4] must be zero):
//   0xF000_0000 LED     r/w   wr_data[7:0], read zero-extended
//   0xF000_0004 CYCLE   r     free-running counter, writes ignored
//   0xF000_0008 TX      w     push wr_data[7:0], reads return 0
//   0xF000_000C STATUS  r/w1c {f_decode, f_misalign, f_overflow} at [10:8],
//                             count at [7:4], full at [1], empty at [0]
// ---------------------------------------------------------------------------
module mmio_memory_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fault
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    REG_LED    = 2'd0,
    REG_CYCLE  = 2'd1,
    REG_TX     = 2'd2,
    REG_STATUS = 2'd3
  } mmio_reg_e;

  // Sticky fault bits, laid out to match STATUS[10:8].
  typedef struct packed {
    logic f_decode;
    logic f_misalign;
    logic f_overflow;
  } faults_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    leds_q;
  logic [31:0]   cycle_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  faults_t       fault_q, fault_d;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic          is_mmio, mmio_hit, misalign, wr_ok;
  mmio_reg_e     reg_sel;
  logic [AW-1:0] ram_idx;

  assign is_mmio  = (mem_addr[31:28] == 4'hF);
  assign mmio_hit = is_mmio && (mem_addr[27:4] == 24'd0);
  assign misalign = |mem_addr[1:0];
  assign reg_sel  = mmio_reg_e'(mem_addr[3:2]);
  // Higher address bits are ignored, so RAM aliases modulo its size.
  assign ram_idx  = mem_addr[AW+1:2];
  // Misaligned writes are dropped in both regions.
  assign wr_ok    = mem_wr_ena && !misalign;

  logic ram_we, led_we, push, w1c;
  assign ram_we = wr_ok && !is_mmio;
  assign led_we = wr_ok && mmio_hit && (reg_sel == REG_LED);
  assign push   = wr_ok && mmio_hit && (reg_sel == REG_TX);
  assign w1c    = wr_ok && mmio_hit && (reg_sel == REG_STATUS);

  // -------------------------------------------------------------------------
  // TX FIFO control
  // -------------------------------------------------------------------------
  logic full, empty, pop, push_ok;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop);

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path through the block can leave it holding state (inferred latch).
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Faults: a set in the same cycle as a W1C clear of that bit wins.
  // -------------------------------------------------------------------------
  faults_t fault_set, fault_clr;
  always_comb begin
    fault_set            = '0;
    fault_set.f_overflow = push && full && !pop;
    fault_set.f_misalign = mem_wr_ena && misalign;
    fault_set.f_decode   = mem_wr_ena && !misalign && is_mmio && !mmio_hit;
    fault_clr            = w1c ? faults_t'(mem_wr_data[10:8]) : '0;
    fault_d              = (fault_q & ~fault_clr) | fault_set;
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds_q   <= '0;
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (led_we)  leds_q   <= mem_wr_data[7:0];
      // Pointers are log2(FIFO_DEPTH) wide, so they wrap at the depth for free.
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: storage arrays have no reset; RAM must survive reset, and FIFO
  // entries are only ever read while count_q says they hold valid data.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_wr_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= mem_wr_data[7:0];
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  logic [31:0] status_word, rd_word;

  always_comb begin
    status_word        = '0;
    status_word[0]     = empty;
    status_word[1]     = full;
    status_word[7:4]   = 4'(count_q);
    status_word[10:8]  = fault_q;
  end

  always_comb begin
    rd_word = '0;
    if (!is_mmio) begin
      rd_word = ram_q[ram_idx];
    end else if (mmio_hit) begin
      unique case (reg_sel)
        REG_LED:    rd_word = {24'd0, leds_q};
        REG_CYCLE:  rd_word = cycle_q;
        REG_TX:     rd_word = '0;
        REG_STATUS: rd_word = status_word;
        default:    rd_word = '0;
      endcase
    end
  end

  // Read data is held at zero for the whole time reset is asserted.
  assign mem_rd_data = rst ? rd_word : 32'd0;
  assign leds        = leds_q;
  assign tx_data     = tx_valid ? fifo_q[rd_ptr_q] : 8'd0;
  assign fault       = |fault_q;

endmodule

// File: tb/tb_mmio_memory_responder.sv
// ---------------------------------------------------------------------------
// Testbench for mmio_memory_responder.
// Stimulus issues one bus operation per clock (driven 1 ns after the rising
// edge) and pushes the expected read word or TX byte into a scoreboard
// queue. A monitor samples on the falling edge: it pops the read queue
// whenever a checked read is on the bus, and the TX queue whenever the DUT
// presents a byte that the sink accepts.
// ---------------------------------------------------------------------------
module tb_mmio_memory_responder;

  localparam logic [31:0] A_LED    = 32'hF000_0000;
  localparam logic [31:0] A_CYCLE  = 32'hF000_0004;
  localparam logic [31:0] A_TX     = 32'hF000_0008;
  localparam logic [31:0] A_STATUS = 32'hF000_000C;
  localparam logic [31:0] A_IDLE   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        mem_wr_ena = 1'b0;
  logic [31:0] mem_rd_data;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        fault;

  logic        rd_chk = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];

  int n_checks = 0;
  int n_errors = 0;

  mmio_memory_responder #(.RAM_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .leds        (leds),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, optionally queue an expected read, wait for the
  // next rising edge, then drop the strobes 1 ns later.
  task automatic op(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                    input logic chk, input logic [31:0] exp, input string name);
    mem_addr    = addr;
    mem_wr_data = wdata;
    mem_wr_ena  = we;
    rd_chk      = chk;
    if (chk) rd_q.push_back('{name: name, exp: exp});
    @(posedge clk);
    #1;
    mem_wr_ena = 1'b0;
    rd_chk     = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    op(addr, data, 1'b1, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    op(addr, 32'd0, 1'b0, 1'b1, exp, name);
  endtask

  task automatic idle();
    op(A_IDLE, 32'd0, 1'b0, 1'b0, 32'd0, "");
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_q.push_back(b);
    wr(A_TX, {24'd0, b});
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  rd_exp_t    mon_e;
  logic [7:0] mon_b;
  always @(negedge clk) begin
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_scoreboard: read on bus with no expected value at %0t", $time);
      end else begin
        mon_e = rd_q.pop_front();
        check(mon_e.name, mem_rd_data, mon_e.exp);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_scoreboard: unexpected byte 0x%02h at %0t", tx_data, $time);
      end else begin
        mon_b = tx_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, mon_b});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Reset state ----
    mem_addr = 32'h0000_0010;
    #2;
    check("rst_leds",     {24'd0, leds},    32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data}, 32'd0);
    check("rst_fault",    {31'd0, fault},   32'd0);
    check("rst_rd_data",  mem_rd_data,      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ---- RAM, aliasing, same-cycle read of a written word ----
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    op(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF, "ram_same_cycle_old");
    rd(32'h0000_0010, 32'h1234_5678, "ram_read");
    rd(32'h0000_0410, 32'h1234_5678, "ram_alias");
    rd(32'h0000_0012, 32'h1234_5678, "ram_misaligned_read");

    // ---- LED ----
    wr(A_LED, 32'h0000_01A5);
    check("leds_after_write", {24'd0, leds}, 32'h0000_00A5);
    rd(A_LED, 32'h0000_00A5, "led_read");

    // A byte in the FIFO that reset must discard.
    wr(A_TX, 32'h0000_0077);
    check("tx_valid_before_rst", {31'd0, tx_valid}, 32'd1);

    // ---- Mid-cycle reset pulse ----
    mem_addr = 32'h0000_0010;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_leds",     {24'd0, leds},     32'd0);
    check("midrst_rd_data",  mem_rd_data,       32'd0);
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd(A_CYCLE, 32'd0, "cycle_after_release");
    rd(A_CYCLE, 32'd1, "cycle_first_edge");
    for (int i = 0; i < 5; i++) idle();
    rd(A_CYCLE, 32'd7, "cycle_delta_6");
    rd(32'h0000_0010, 32'h1234_5678, "ram_survives_rst");
    wr(A_CYCLE, 32'h0000_0000);
    rd(A_STATUS, 32'h0000_0001, "cycle_write_no_fault");

    // ---- FIFO fill, overflow, drain ----
    tx_ready = 1'b0;
    push_tx(8'h41);
    check("tx_valid_first_push", {31'd0, tx_valid}, 32'd1);
    check("tx_data_head",        {24'd0, tx_data},  32'h41);
    push_tx(8'h42);
    push_tx(8'h43);
    push_tx(8'h44);
    rd(A_STATUS, 32'h0000_0042, "status_full");
    wr(A_TX, 32'h0000_0045);
    rd(A_STATUS, 32'h0000_0142, "status_overflow");
    check("fault_overflow", {31'd0, fault}, 32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    check("tx_valid_drained", {31'd0, tx_valid}, 32'd0);
    rd(A_STATUS, 32'h0000_0101, "status_empty_ovf");
    wr(A_STATUS, 32'h0000_0100);
    check("fault_cleared_ovf", {31'd0, fault}, 32'd0);

    // ---- Push while full with a same-cycle pop ----
    tx_ready = 1'b0;
    push_tx(8'h51);
    push_tx(8'h52);
    push_tx(8'h53);
    push_tx(8'h54);
    tx_ready = 1'b1;
    push_tx(8'h55);
    rd(A_STATUS, 32'h0000_0042, "status_full_push_pop");
    for (int i = 0; i < 3; i++) idle();
    check("tx_valid_drained2", {31'd0, tx_valid}, 32'd0);
    rd(A_STATUS, 32'h0000_0001, "status_empty");
    tx_ready = 1'b0;

    // ---- Misalign, decode, W1C ----
    wr(32'h0000_0013, 32'hCAFE_F00D);
    rd(32'h0000_0010, 32'h1234_5678, "ram_misaligned_write_dropped");
    rd(A_STATUS, 32'h0000_0201, "status_misalign");
    wr(32'hF000_0100, 32'h0000_00FF);
    rd(A_STATUS, 32'h0000_0601, "status_decode");
    check("fault_set", {31'd0, fault}, 32'd1);
    rd(32'hF000_0100, 32'd0, "undecoded_read");
    rd(A_TX, 32'd0, "tx_read_zero");
    rd(A_LED, 32'h0000_00A5 & 32'd0, "led_after_rst");
    wr(A_STATUS, 32'h0000_0700);
    rd(A_STATUS, 32'h0000_0001, "status_w1c_all");
    check("fault_clear", {31'd0, fault}, 32'd0);

    // ---- CYCLE wrap ----
    force dut.cycle_q = 32'hFFFF_FFFF;
    mem_addr = A_CYCLE;
    rd_chk   = 1'b1;
    rd_q.push_back('{name: "cycle_forced", exp: 32'hFFFF_FFFF});
    @(negedge clk);
    #1;
    release dut.cycle_q;
    rd_chk = 1'b0;
    @(posedge clk);
    #1;
    rd(A_CYCLE, 32'd0, "cycle_wrap");

    idle();
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
